// File: rtl/logarithmic_afpm_pkg.sv
// Shared binary16 format constants and sequencing states for the Mitchell
// logarithmic multiplier tile.
package logarithmic_afpm_pkg;

   localparam int          EXP_W        = 5;
   localparam int          MAN_W        = 10;
   localparam logic [14:0] BIAS_PATTERN = 15'h3C00;
   localparam logic [4:0]  EXP_MAX      = 5'h1F;
   localparam logic [14:0] INF_MAG      = 15'h7C00;
   localparam logic [15:0] QNAN         = 16'h7E00;

   typedef enum logic [1:0] {
      LOAD_LO = 2'd0,
      LOAD_HI = 2'd1,
      OUT_LO  = 2'd2,
      OUT_HI  = 2'd3
   } afpm_state_e;

endpackage

// File: rtl/logarithmic_afpm_mitchell_core.sv
// Combinational Mitchell approximate binary16 multiply: the product magnitude is
// the sum of the operand bit patterns minus the exponent bias pattern.
module afpm_mitchell_core
   import logarithmic_afpm_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] res
);

   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   logic             sign_r;
   logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [16:0]      sum;

   assign exp_a  = a[14:10];
   assign exp_b  = b[14:10];
   assign man_a  = a[9:0];
   assign man_b  = b[9:0];
   assign sign_r = a[15] ^ b[15];

   assign nan_a  = (exp_a == EXP_MAX) && (man_a != '0);
   assign nan_b  = (exp_b == EXP_MAX) && (man_b != '0);
   assign inf_a  = (exp_a == EXP_MAX) && (man_a == '0);
   assign inf_b  = (exp_b == EXP_MAX) && (man_b == '0);
   assign zero_a = (exp_a == '0);
   assign zero_b = (exp_b == '0);

   // Mantissa carry rolling into the exponent is the intended log-domain add.
   // Both magnitudes are below 16'h7C00, so bit 16 is a true sign bit.
   assign sum = {2'b00, a[14:0]} + {2'b00, b[14:0]} - {2'b00, BIAS_PATTERN};

   always_comb begin
      res = {sign_r, sum[14:0]};
      if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
         res = QNAN;
      end else if (inf_a || inf_b) begin
         res = {sign_r, INF_MAG};
      end else if (zero_a || zero_b) begin
         res = {sign_r, 15'h0000};
      end else if (sum[16] || (sum < 17'h00400)) begin
         res = {sign_r, 15'h0000};
      end else if (sum >= {2'b00, INF_MAG}) begin
         res = {sign_r, INF_MAG};
      end
   end

endmodule

// File: rtl/logarithmic_afpm.sv
// Byte-serial front end for the Mitchell multiplier: two load cycles, two
// output cycles, repeating, gated by ena.
//
// state   | meaning
// LOAD_LO | capture operand low bytes, output 00
// LOAD_HI | capture operand high bytes and compute product, output 00
// OUT_LO  | present product low byte
// OUT_HI  | present product high byte
module logarithmic_afpm
   import logarithmic_afpm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   afpm_state_e state, state_nxt;
   logic [15:0] a_reg, b_reg, res_reg;
   logic [15:0] core_res;

   // The high bytes are taken straight from the bus so the product is ready
   // on the same edge that completes the operands.
   afpm_mitchell_core u_core (
      .a   ({ui_in,  a_reg[7:0]}),
      .b   ({uio_in, b_reg[7:0]}),
      .res (core_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD_LO;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (ena) begin
         unique case (state)
            LOAD_LO: state_nxt = LOAD_HI;
            LOAD_HI: state_nxt = OUT_LO;
            OUT_LO:  state_nxt = OUT_HI;
            OUT_HI:  state_nxt = LOAD_LO;
            default: state_nxt = LOAD_LO;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= 16'h0000;
         b_reg   <= 16'h0000;
         res_reg <= 16'h0000;
      end else if (ena) begin
         if (state == LOAD_LO) begin
            a_reg[7:0] <= ui_in;
            b_reg[7:0] <= uio_in;
         end else if (state == LOAD_HI) begin
            a_reg[15:8] <= ui_in;
            b_reg[15:8] <= uio_in;
            res_reg     <= core_res;
         end
      end
   end

   always_comb begin
      uo_out = 8'h00;
      if (state == OUT_LO) begin
         uo_out = res_reg[7:0];
      end else if (state == OUT_HI) begin
         uo_out = res_reg[15:8];
      end
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: directed vector table, random
// operands against a reference model, ena stall and reset-abort sequences.
module tb_logarithmic_afpm;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;

   logarithmic_afpm dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_res;
   } vec_t;

   // Reference: operand values are classified, then the product exponent and
   // mantissa are formed by adding the operands' log2 approximations.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, ma, mb, e, m;
      logic sr;
      ea = int'(a[14:10]); ma = int'(a[9:0]);
      eb = int'(b[14:10]); mb = int'(b[9:0]);
      sr = a[15] ^ b[15];
      if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
      if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
      if (ea == 31 || eb == 31) return {sr, 15'h7C00};
      if (ea == 0 || eb == 0) return {sr, 15'h0000};
      // log2(1+m) ~ m: add fractions, carrying a whole unit into the exponent.
      e = (ea - 15) + (eb - 15) + 15;
      m = ma + mb;
      if (m >= 1024) begin
         m = m - 1024;
         e = e + 1;
      end
      if (e < 1) return {sr, 15'h0000};
      if (e > 30) return {sr, 15'h7C00};
      return {sr, 5'(e), 10'(m)};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
      end
   endtask

   // Entered at a falling edge with the DUT in LOAD_LO; returns at a falling
   // edge with the DUT back in LOAD_LO. hold>0 stalls ena while in LOAD_HI.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input int hold, input string name);
      ui_in  = a[7:0];
      uio_in = b[7:0];
      check({name, "_ll"}, uo_out, 8'h00);
      @(negedge clk);
      if (hold > 0) begin
         ena = 1'b0;
         for (int i = 0; i < hold; i++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            @(negedge clk);
            check({name, "_stall"}, uo_out, 8'h00);
         end
         ena = 1'b1;
      end
      ui_in  = a[15:8];
      uio_in = b[15:8];
      check({name, "_lh"}, uo_out, 8'h00);
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      check({name, "_lo"}, uo_out, exp_res[7:0]);
      @(negedge clk);
      check({name, "_hi"}, uo_out, exp_res[15:8]);
      @(negedge clk);
   endtask

   vec_t vecs[10];

   initial begin
      logic [15:0] ra, rb;

      vecs[0] = '{16'h3E00, 16'h4200, 16'h4400};
      vecs[1] = '{16'h0101, 16'h0101, 16'h0000};
      vecs[2] = '{16'hBC00, 16'h4000, 16'hC000};
      vecs[3] = '{16'h7C00, 16'h0000, 16'h7E00};
      vecs[4] = '{16'hFC00, 16'h3C00, 16'hFC00};
      vecs[5] = '{16'h7E01, 16'h3C00, 16'h7E00};
      vecs[6] = '{16'h7800, 16'h7800, 16'h7C00};
      vecs[7] = '{16'h0400, 16'h0400, 16'h0000};
      vecs[8] = '{16'h8400, 16'h0400, 16'h8000};
      vecs[9] = '{16'h3E00, 16'h3E00, 16'h4000};

      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_uo", uo_out, 8'h00);
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].exp_res, 0, $sformatf("vec%0d", i));
      end

      // Stall in LOAD_HI with junk bytes on the bus; product must be unchanged.
      run_txn(16'h3E00, 16'h4200, 16'h4400, 3, "stall");

      // Abort in OUT_LO: output drops at once and the next product is clean.
      ui_in = 8'h00; uio_in = 8'h01;
      @(negedge clk);
      ui_in = 8'h3C; uio_in = 8'h3C;
      @(negedge clk);
      check("rst_pre_lo", uo_out, 8'h01);
      rst = 1'b1;
      #1;
      check("rst_abort", uo_out, 8'h00);
      @(negedge clk);
      check("rst_held", uo_out, 8'h00);
      rst = 1'b0;
      run_txn(16'hBC00, 16'h4000, 16'hC000, 0, "post_rst");

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 1) rb[14:10] = 5'($urandom_range(10, 20));
         if (i % 4 == 2) ra[14:10] = 5'($urandom_range(10, 20));
         run_txn(ra, rb, ref_mul(ra, rb), (i % 17 == 5) ? 2 : 0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logarithmic_afpm.md
Name: logarithmic_afpm

Overview:
Approximate half-precision floating-point multiplier using Mitchell's logarithmic approximation. Product ≈ A + B − bias, computed on the raw IEEE-754 binary16 bit patterns.
Operands arrive byte-serially over two 8-bit input buses. The 16-bit result is returned byte-serially on an 8-bit output bus.
Top-level user block of the TinyTapeout-style tile; it has no other dependencies.

Parameters:
none (format constants are fixed; see Decomposition)

Ports:
clk      input   1  single clock; all state on rising edge
rst      input   1  asynchronous, active-high reset
ena      input   1  design enable; low = FSM and registers hold
ui_in    input   8  operand A byte (low byte first, then high byte)
uio_in   input   8  operand B byte (same phase as A)
uo_out   output  8  result byte (low byte, then high byte)
uio_out  output  8  tied 8'h00
uio_oe   output  8  tied 8'h00 (uio all inputs)

Behaviour:
- Repeating 4-state FSM: LOAD_LO → LOAD_HI → OUT_LO → OUT_HI → LOAD_LO.
  - Advances one state per clk edge when ena=1; holds when ena=0.
- Reset (async, rst=1): state=LOAD_LO; a_reg, b_reg, res_reg = 16'h0000.
  - First rising edge after rst deasserts samples the low bytes.
- LOAD_LO edge: a_reg[7:0]<=ui_in; b_reg[7:0]<=uio_in.
- LOAD_HI edge: a_reg[15:8]<=ui_in; b_reg[15:8]<=uio_in.
  - On the same edge, res_reg <= f({ui_in,a_reg[7:0]}, {uio_in,b_reg[7:0]}), i.e. computed from the full operands, including the incoming high bytes.
- uo_out is a combinational decode of the registered state:
  - res_reg[7:0] in OUT_LO.
  - res_reg[15:8] in OUT_HI.
  - 8'h00 in LOAD_LO and LOAD_HI.
- Latency: low result byte is valid the cycle after the high-operand edge; high result byte one cycle later. Throughput is one product per 4 cycles.
- f(A,B), with sA=A[15], eA=A[14:10], mA=A[9:0] (same fields for B), sR = sA^sB:
  - NaN if either input has e=31 and m≠0, or Inf×zero → 16'h7E00 (canonical quiet NaN, sign 0).
  - Else either input Inf (e=31) → {sR,15'h7C00}.
  - Else either input e=0 (zero or subnormal, flushed) → {sR,15'h0000}.
  - Else sum = {2'b0,A[14:0]} + {2'b0,B[14:0]} − 17'h03C00, computed in 17-bit two's complement.
    - Mantissa carry into the exponent is the intended Mitchell behaviour.
  - If sum is negative or sum < 17'h00400 (underflow) → {sR,15'h0000}.
  - If sum ≥ 17'h07C00 (overflow) → {sR,15'h7C00}.
  - Otherwise → {sR,sum[14:0]}.
- Mantissa is truncated only; no rounding.
- Reset mid-operation aborts the transaction, clears all registers and drives uo_out to 00 immediately.
- ena dropping mid-transaction freezes the state. Bytes presented while ena=0 are ignored.

Decomposition:
- Package logarithmic_afpm_pkg holds:
  - EXP_W=5, MAN_W=10, BIAS_PATTERN=15'h3C00, EXP_MAX=5'h1F, INF_MAG=15'h7C00, QNAN=16'h7E00.
  - State enum {LOAD_LO, LOAD_HI, OUT_LO, OUT_HI}.
- One combinational sub-module, afpm_mitchell_core, implements f(A,B) (16b, 16b → 16b).
- The top holds the FSM, byte registers and output mux.

Test Plan:
- A=0x3E00 (1.5), B=0x4200 (3.0), low bytes 00/00 then high 3E/42 → uo_out 0x00 during OUT_LO, 0x44 during OUT_HI (result 0x4400 = 4.0, Mitchell approximation of 4.5).
- A=0x0101, B=0x0101 (subnormals) → result 0x0000; A=0xBC00 (−1), B=0x4000 (2) → 0xC000 (−2, exact).
- A=0x7C00 (+Inf), B=0x0000 → 0x7E00; A=0xFC00, B=0x3C00 → 0xFC00; A=0x7E01 (NaN), B=0x3C00 → 0x7E00.
- Overflow: A=0x7800, B=0x7800 → 0x7C00. Underflow: A=0x0400, B=0x0400 → 0x0000. Negative underflow: A=0x8400, B=0x0400 → 0x8000.
- Back-to-back transactions over 8 cycles with different operands → results appear in the correct phases. Hold ena=0 for 3 cycles mid-load → identical result after resume.
- Assert rst during OUT_LO → uo_out=00 immediately; next product loads correctly from LOAD_LO.
